mem_dma: RTL and testbench
==========================

# mem_dma

Word-copy DMA engine acting as an initiator on the native valid/ready memory bus used by the CPU and its peripherals (PRNG, UART, RAM). Given a source address, destination address and word count, it reads each word and writes it back out, one bus transaction at a time, and reports completion or a bus timeout. It sits beside the CPU as a second bus master, ahead of the bus arbiter.

## Interface

- `LEN_W`, 16, width of the word-count input and internal remaining-word counter.
- `TIMEOUT`, 1024, number of consecutive cycles `mem_valid` may stay high without `mem_ready` before the transfer aborts; must be ≥ 2.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only while idle.
- `src_addr`  in  32  source byte address, sampled with `start`; bits [1:0] ignored.
- `dst_addr`  in  32  destination byte address, sampled with `start`; bits [1:0] ignored.
- `word_count`  in  LEN_W  number of 32-bit words to copy, sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the transfer ends.
- `done`  out  1  one-cycle pulse at the end of every accepted transfer, including aborts.
- `error`  out  1  set with `done` on timeout abort; held until the next accepted `start`.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus acknowledge from the responder.
- `mem_instr`  out  1  constant 0.
- `mem_wstrb`  out  4  4'h0 for reads, 4'hF for writes.
- `mem_wdata`  out  32  write data.
- `mem_addr`  out  32  word-aligned byte address; bits [1:0] always 0.
- `mem_rdata`  in  32  read data; valid in the cycle `mem_ready` is high.

## Operation

- States: IDLE, RD, RD_GAP, WR, WR_GAP.
- IDLE: `start` with `word_count` ≠ 0 latches src, dst, count, clears `error`, and moves to RD. `start` with `word_count` = 0 clears `error`, emits `done` next cycle, stays IDLE, issues no bus access, and keeps `busy` low.
- RD: `mem_valid`=1, `mem_addr`=src pointer, `mem_wstrb`=0. On `mem_ready`, capture `mem_rdata` into the data buffer and move to RD_GAP.
- RD_GAP: `mem_valid`=0 for exactly one cycle, then WR. The gap is mandatory because responders derive ready from the level of valid.
- WR: `mem_valid`=1, `mem_addr`=dst pointer, `mem_wdata`=buffer, `mem_wstrb`=4'hF. On `mem_ready`, decrement remaining count and add 4 to both pointers. If the count reaches 0, go to IDLE with `done`=1. Otherwise go to WR_GAP.
- WR_GAP: `mem_valid`=0 for one cycle, then RD.
- Pointers wrap modulo 2^32; no error is raised on wrap.
- `start` outside IDLE is ignored; latched parameters do not change.
- Watchdog:
  - Counts cycles in RD or WR with `mem_ready` low.
  - Clears on every `mem_ready` and in every non-RD/WR state.
  - When the count reaches TIMEOUT, the engine drops `mem_valid` next cycle, returns to IDLE, and pulses `done` with `error`=1.
  - The data buffer is not written on abort.
- `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable for the whole time `mem_valid` is high.

## Timing

- All outputs are registered.
- Reset values: `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `mem_instr`=0, `busy`=0, `done`=0, `error`=0, state=IDLE.
- Reset takes effect asynchronously mid-transfer. `mem_valid` falls immediately and no partial write completes afterwards.
- Latency:
  - `start` at edge N gives `mem_valid` high and `busy` high after edge N.
  - A transaction completes on the rising edge where `mem_valid` & `mem_ready` are both high.
  - With `mem_ready` high in the first valid cycle, each transaction takes 2 cycles (valid + gap), i.e. 4 cycles per word. A K-word copy takes 4K cycles from first `mem_valid` to `done`.
- `done` and `busy` fall are simultaneous: both are registered on the final write acknowledge (or the timeout) edge, so `done` is high in the cycle after it and `busy` is low from that cycle.
- `mem_ready` is ignored when `mem_valid` is low.
- A `start` in the same cycle as `done` is accepted, because the state is IDLE in that cycle.

## Structure

- Shared package `mem_bus_pkg` holds:
  - the state enum;
  - constants `WSTRB_NONE` = 4'h0, `WSTRB_FULL` = 4'hF and `WORD_BYTES` = 4.
- Sub-module `bus_watchdog`: parameter TIMEOUT; inputs `clk`, `reset`, `arm`, `ack`; output `expired`. It is reused by other bus masters.
- The remainder is a single FSM module.

## Test plan

- Copy 3 words, src=0x100, dst=0x200, responder with zero wait states holding 0xA1,0xB2,0xC3 -> writes to 0x200/0x204/0x208 carry those values with wstrb=F; `done` arrives 12 cycles after first `mem_valid`; `error`=0.
- Same copy with a responder inserting 3 wait states per access -> identical data; address/data stable while valid is high; exactly one idle cycle between transactions.
- `word_count`=0 -> no `mem_valid` ever; `done` pulses 1 cycle after `start`; `busy` stays 0.
- TIMEOUT=8, responder never readies -> `mem_valid` is high for exactly 8 cycles, then `done`=1 and `error`=1; next `start` clears `error`.
- src=0xFFFF_FFFC, 2 words -> second read is at 0x0000_0000; misaligned dst=0x203 is issued as 0x200.
- Reset asserted while in WR with `mem_valid` high -> `mem_valid` low immediately; after release, engine is IDLE and the next `start` performs a normal copy.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for initiators on the native valid/ready memory bus.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdGap,
    StWr,
    StWrGap
  } dma_state_e;

  localparam logic [3:0]  WSTRB_NONE = 4'h0;
  localparam logic [3:0]  WSTRB_FULL = 4'hF;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mem_dma_if.sv
// Native valid/ready memory bus as seen by one initiator and its responder.
interface mem_dma_if;

  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/bus_watchdog.sv
// Flags a bus request that has waited TIMEOUT consecutive cycles without acknowledge.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic ack,
  output logic expired
);

  localparam int unsigned     CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (!arm || ack) begin
      r_count <= '0;
    end else if (r_count != Last) begin
      r_count <= r_count + CntW'(1);
    end
  end

  // Fires in the TIMEOUT-th waiting cycle so the request is dropped on that edge.
  assign expired = arm && !ack && (r_count == Last);

endmodule

// File: rtl/mem_dma.sv
// Word-copy DMA initiator: reads one word, writes it back out, repeats for word_count words.
module mem_dma
  import mem_bus_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  mem_dma_if.master        bus
);

  dma_state_e       r_state, w_state_d;
  logic [31:0]      r_src, w_src_d, r_dst, w_dst_d, r_buf, w_buf_d;
  logic [LEN_W-1:0] r_count, w_count_d;
  logic             r_valid, w_valid_d;
  logic [31:0]      r_addr, w_addr_d, r_wdata, w_wdata_d;
  logic [3:0]       r_wstrb, w_wstrb_d;
  logic             r_busy, w_busy_d, r_done, w_done_d, r_error, w_error_d;
  logic             w_expired, w_last, w_accept;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .arm     (r_valid),
    .ack     (bus.mem_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_buf   <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= WSTRB_NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_src   <= w_src_d;
      r_dst   <= w_dst_d;
      r_buf   <= w_buf_d;
      r_count <= w_count_d;
      r_valid <= w_valid_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_wstrb <= w_wstrb_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_error <= w_error_d;
    end
  end

  assign w_accept = (r_state == StIdle) && start;

  always_comb begin
    w_state_d = r_state;
    w_src_d   = r_src;
    w_dst_d   = r_dst;
    w_buf_d   = r_buf;
    w_count_d = r_count;
    w_last    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start && (word_count != '0)) begin
          w_state_d = StRd;
          w_src_d   = src_addr & 32'hFFFF_FFFC;
          w_dst_d   = dst_addr & 32'hFFFF_FFFC;
          w_count_d = word_count;
        end
      end
      StRd: begin
        if (w_expired) begin
          w_state_d = StIdle;
        end else if (bus.mem_ready) begin
          w_buf_d   = bus.mem_rdata;
          w_state_d = StRdGap;
        end
      end
      StRdGap: w_state_d = StWr;
      StWr: begin
        if (w_expired) begin
          w_state_d = StIdle;
        end else if (bus.mem_ready) begin
          w_count_d = r_count - LEN_W'(1);
          w_src_d   = r_src + 32'(WORD_BYTES);
          w_dst_d   = r_dst + 32'(WORD_BYTES);
          if (r_count == LEN_W'(1)) begin
            w_state_d = StIdle;
            w_last    = 1'b1;
          end else begin
            w_state_d = StWrGap;
          end
        end
      end
      StWrGap: w_state_d = StRd;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they change only on clock edges.
  always_comb begin
    w_valid_d = (w_state_d == StRd) || (w_state_d == StWr);
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_wstrb_d = WSTRB_NONE;
    if (w_state_d == StRd) begin
      w_addr_d = w_src_d;
    end else if (w_state_d == StWr) begin
      w_addr_d  = w_dst_d;
      w_wdata_d = r_buf;
      w_wstrb_d = WSTRB_FULL;
    end
    w_busy_d  = (w_state_d != StIdle);
    w_done_d  = w_last || w_expired || (w_accept && (word_count == '0));
    w_error_d = r_error;
    if (w_accept) begin
      w_error_d = 1'b0;
    end else if (w_expired) begin
      w_error_d = 1'b1;
    end
  end

  assign bus.mem_valid = r_valid;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wstrb = r_wstrb;
  assign bus.mem_instr = 1'b0;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma with a wait-state configurable responder (TIMEOUT = 8).
module tb_mem_dma;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_count;
  logic        busy, done, error;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ws      = 0;
  bit          stall   = 1'b0;
  int          wait_cnt;

  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];

  mem_dma_if bus ();

  mem_dma #(
    .LEN_W   (16),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0000_00A1;
      32'h0000_0104: return 32'h0000_00B2;
      32'h0000_0108: return 32'h0000_00C3;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Responder: ready follows the level of valid after ws wait cycles.
  assign bus.mem_ready = bus.mem_valid && !stall && (wait_cnt == ws);
  assign bus.mem_rdata = rd_word(bus.mem_addr);

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (bus.mem_valid && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  logic        prev_valid = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (bus.mem_valid && prev_valid && !prev_ack) begin
        n_tests++;
        if (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata ||
            bus.mem_wstrb !== prev_wstrb) begin
          n_fail++;
          $display("FAIL stable_while_valid got addr=%h wdata=%h wstrb=%h want %h %h %h",
                   bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, prev_addr, prev_wdata, prev_wstrb);
        end
      end
      if (prev_ack) begin
        n_tests++;
        if (bus.mem_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_after_ack got valid=%b want 0", bus.mem_valid);
        end
      end
      if (bus.mem_valid && bus.mem_ready) begin
        n_tests++;
        if (bus.mem_wstrb === 4'h0) begin
          if (exp_rd.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read got addr=%h want none", bus.mem_addr);
          end else begin
            logic [31:0] e;
            e = exp_rd.pop_front();
            if (bus.mem_addr !== e) begin
              n_fail++;
              $display("FAIL read_addr got %h want %h", bus.mem_addr, e);
            end
          end
        end else begin
          if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write got addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
          end else begin
            wr_t w;
            w = exp_wr.pop_front();
            if (bus.mem_addr !== w.addr || bus.mem_wdata !== w.data || bus.mem_wstrb !== 4'hF) begin
              n_fail++;
              $display("FAIL write got addr=%h data=%h wstrb=%h want %h %h F",
                       bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, w.addr, w.data);
            end
          end
        end
      end
      if (bus.mem_instr !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL mem_instr got %b want 0", bus.mem_instr);
      end
      prev_valid = bus.mem_valid;
      prev_ack   = bus.mem_valid && bus.mem_ready;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
      prev_wstrb = bus.mem_wstrb;
    end
  end

  // Called at a negedge; leaves the bench at the negedge of the first busy cycle.
  task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n, input bit push);
    logic [31:0] sa, da;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    if (push) begin
      for (int i = 0; i < n; i++) begin
        exp_rd.push_back(sa + 32'(4 * i));
        exp_wr.push_back('{addr: da + 32'(4 * i), data: rd_word(sa + 32'(4 * i))});
      end
    end
    src_addr   = s;
    dst_addr   = d;
    word_count = 16'(n);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done got no done after %0d cycles want done", cyc);
    end
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained got rd=%0d wr=%0d pending want 0 0", name, exp_rd.size(),
               exp_wr.size());
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.mem_valid, bus.mem_instr, busy, done, error} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got valid/instr/busy/done/error=%b want 00000",
               {bus.mem_valid, bus.mem_instr, busy, done, error});
    end
    n_tests++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_bus got addr=%h wdata=%h wstrb=%h want 0 0 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.mem_valid, busy, done} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got valid/busy/done=%b want 000", {bus.mem_valid, busy, done});
    end
  endtask

  task automatic test_copy_zero_wait;
    int cyc;
    ws = 0;
    kick(32'h100, 32'h200, 3, 1'b1);
    n_tests++;
    if (busy !== 1'b1 || bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL copy_first_cycle got busy=%b valid=%b addr=%h want 1 1 00000100",
               busy, bus.mem_valid, bus.mem_addr);
    end
    wait_done(1, cyc);
    n_tests++;
    if (cyc != 12) begin
      n_fail++;
      $display("FAIL copy_latency got %0d cycles want 12", cyc);
    end
    n_tests++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL copy_end got error=%b busy=%b want 0 0", error, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse got done=%b want 0", done);
    end
    check_drained("copy");
  endtask

  task automatic test_wait_states;
    int cyc;
    ws = 3;
    kick(32'h100, 32'h200, 3, 1'b1);
    repeat (3) @(negedge clk);
    // A start while busy must be ignored; the scoreboard would see extra traffic.
    kick(32'h500, 32'h600, 1, 1'b0);
    wait_done(5, cyc);
    n_tests++;
    if (cyc != 30) begin
      n_fail++;
      $display("FAIL wait_latency got %0d cycles want 30", cyc);
    end
    repeat (3) @(negedge clk);
    check_drained("wait");
  endtask

  task automatic test_zero_count;
    ws = 0;
    kick(32'h100, 32'h200, 0, 1'b0);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done got done=%b busy=%b valid=%b want 1 0 0", done, busy, bus.mem_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.mem_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_quiet got done=%b busy=%b valid=%b want 0 0 0", done, busy,
                 bus.mem_valid);
      end
    end
  endtask

  task automatic test_timeout;
    int vcyc, k;
    stall = 1'b1;
    kick(32'h100, 32'h200, 1, 1'b0);
    vcyc = 0;
    k    = 0;
    while (done !== 1'b1 && k < 100) begin
      if (bus.mem_valid === 1'b1) vcyc++;
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (vcyc != 8 || k != 8) begin
      n_fail++;
      $display("FAIL timeout_valid_cycles got %0d (done after %0d) want 8 (8)", vcyc, k);
    end
    n_tests++;
    if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0 || bus.mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort got done=%b error=%b busy=%b valid=%b want 1 1 0 0",
               done, error, busy, bus.mem_valid);
    end
    stall = 1'b0;
    @(negedge clk);
    n_tests++;
    if (error !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL error_held got error=%b done=%b want 1 0", error, done);
    end
    kick(32'h100, 32'h200, 0, 1'b0);
    n_tests++;
    if (error !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL error_cleared got error=%b done=%b want 0 1", error, done);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    int cyc;
    ws = 1;
    kick(32'hFFFF_FFFC, 32'h203, 2, 1'b1);
    wait_done(1, cyc);
    n_tests++;
    if (cyc != 12 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end got cycles=%0d error=%b want 12 0", cyc, error);
    end
    check_drained("wrap");
  endtask

  task automatic test_reset_mid;
    int k, cyc;
    ws = 2;
    kick(32'h100, 32'h300, 2, 1'b1);
    k = 0;
    while (!(bus.mem_valid === 1'b1 && bus.mem_wstrb === 4'hF) && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (bus.mem_valid !== 1'b1 || bus.mem_wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL reach_write got valid=%b wstrb=%h want 1 F", bus.mem_valid, bus.mem_wstrb);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.mem_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got valid=%b busy=%b want 0 0", bus.mem_valid, busy);
    end
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got busy=%b done=%b valid=%b want 0 0 0", busy, done,
               bus.mem_valid);
    end
    ws = 0;
    kick(32'h108, 32'h400, 2, 1'b1);
    wait_done(1, cyc);
    n_tests++;
    if (cyc != 8) begin
      n_fail++;
      $display("FAIL post_reset_copy got %0d cycles want 8", cyc);
    end
    check_drained("reset_mid");
  endtask

  task automatic test_back_to_back;
    int cyc;
    ws = 0;
    kick(32'h104, 32'h500, 1, 1'b1);
    wait_done(1, cyc);
    n_tests++;
    if (cyc != 4) begin
      n_fail++;
      $display("FAIL b2b_first got %0d cycles want 4", cyc);
    end
    kick(32'h108, 32'h504, 2, 1'b1);
    n_tests++;
    if (busy !== 1'b1 || bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h108) begin
      n_fail++;
      $display("FAIL b2b_accept got busy=%b valid=%b addr=%h want 1 1 00000108",
               busy, bus.mem_valid, bus.mem_addr);
    end
    wait_done(1, cyc);
    n_tests++;
    if (cyc != 8) begin
      n_fail++;
      $display("FAIL b2b_second got %0d cycles want 8", cyc);
    end
    check_drained("b2b");
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    src_addr   = '0;
    dst_addr   = '0;
    word_count = '0;
    test_reset;
    test_copy_zero_wait;
    test_wait_states;
    test_zero_count;
    test_timeout;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
